// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
// Package  : io_port_pkg
// Brief    : Word width and status-word bit layout shared by the I/O ports.
// Revision : 1.0 - initial release
// ============================================================================
package io_port_pkg;

    localparam int WORD_W        = 32;

    // Bit positions used by the I/O read mux when it assembles the status word
    localparam int EMPTY_BIT     = 0;
    localparam int FULL_BIT      = 1;
    localparam int UNDERFLOW_BIT = 2;
    localparam int COUNT_LSB     = 8;

endpackage
`default_nettype wire

// File: rtl/register_in_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : register_in_fifo_if
// Brief     : Producer handshake, processor read strobe and status of the input FIFO.
// Revision  : 1.0 - initial release
// ============================================================================
interface register_in_fifo_if
    import io_port_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);

    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             load;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             underflow;
    logic             clr_flags;

    modport master (
        output ext_data, ext_valid, load, clr_flags,
        input  ext_ready, data_out, empty, full, count, underflow
    );

    modport slave (
        input  ext_data, ext_valid, load, clr_flags,
        output ext_ready, data_out, empty, full, count, underflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mem
// Brief    : DEPTH x WIDTH storage, one clocked write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             wr_en,
    input  wire logic [AW-1:0]    wr_addr,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic [AW-1:0]    rd_addr,
    output logic      [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents are only ever read after a matching write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/register_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : register_in_fifo
// Brief    : Processor input port: handshake-fed FIFO popped into a held register.
// Revision : 1.0 - initial release
// ============================================================================
module register_in_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input wire logic         clk,
    input wire logic         reset,
    register_in_fifo_if.slave bus
);

    localparam int               c_addr_w     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_underflow;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [WIDTH-1:0]    w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    assign w_push  = bus.ext_valid && !w_full;
    assign w_pop   = bus.load && !w_empty;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_addr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.ext_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_addr_w'(1);
                r_data_out <= w_rd_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A fresh underflow outranks a clear in the same cycle
            if (bus.load && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.ext_ready = !w_full;
    assign bus.data_out  = r_data_out;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_register_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_in_fifo
// Brief    : Scoreboard bench for register_in_fifo (WIDTH=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_in_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    register_in_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    register_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: words accepted by the FIFO, oldest first
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_uf;

    wire [38:0] dut_status = {bus.data_out, bus.count, bus.empty, bus.full,
                              bus.ext_ready, bus.underflow};

    function automatic logic [38:0] model_status();
        logic [2:0] c;
        c = 3'(sb.size());
        return {m_dout, c, (c == 3'd0), (c == 3'd4), (c != 3'd4), m_uf};
    endfunction

    // Drive one cycle of stimulus, then advance the scoreboard across the edge
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ld,
                        input logic clr, input logic rst);
        int pre;
        bus.ext_valid = v;
        bus.ext_data  = d;
        bus.load      = ld;
        bus.clr_flags = clr;
        reset         = rst;
        @(posedge clk);
        pre = sb.size();
        if (rst) begin
            sb.delete();
            m_dout = '0;
            m_uf   = 1'b0;
        end else begin
            if (ld && pre > 0) m_dout = sb.pop_front();
            if (ld && pre == 0)  m_uf = 1'b1;
            else if (clr)        m_uf = 1'b0;
            if (v && pre < DEPTH) sb.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_status !== {32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_status,
                     {32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_status !== model_status()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", dut_status, model_status());
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_status !== model_status()) begin
                failures++;
                $display("FAIL fill_status[%0d] got=%h exp=%h", i, dut_status, model_status());
            end
        end
        checks++;
        if ({bus.count, bus.full, bus.ext_ready} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fill_full got=%b exp=%b", {bus.count, bus.full, bus.ext_ready},
                     {3'd4, 1'b1, 1'b0});
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_status !== model_status()) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, dut_status, model_status());
            end
        end
        // Load while full: the pop happens, the held word is still refused
        step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.data_out, bus.count} !== {32'hA0, 3'd3}) begin
            failures++;
            $display("FAIL stall_pop got=%h/%0d exp=a0/3", bus.data_out, bus.count);
        end
        step(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_status !== model_status() || bus.count !== 3'd4) begin
            failures++;
            $display("FAIL stall_accept got=%h exp=%h", dut_status, model_status());
        end
    endtask

    task automatic test_wrap_order();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.data_out !== exp || dut_status !== model_status()) begin
                failures++;
                $display("FAIL drain[%0d] got=%h exp=%h", i, bus.data_out, exp);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.data_out !== 32'hB0 + 32'(i) || dut_status !== model_status()) begin
                failures++;
                $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, bus.data_out, 32'hB0 + 32'(i));
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_empty got=%b exp=1", bus.empty);
        end
    endtask

    task automatic test_concurrent();
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.data_out, bus.count} !== {32'h11, 3'd2} || dut_status !== model_status()) begin
            failures++;
            $display("FAIL concurrent got=%h exp=%h", dut_status, model_status());
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_status !== model_status()) begin
                failures++;
                $display("FAIL concurrent_drain[%0d] got=%h exp=%h", i, dut_status, model_status());
            end
        end
        checks++;
        if (bus.data_out !== 32'hC0) begin
            failures++;
            $display("FAIL concurrent_last got=%h exp=c0", bus.data_out);
        end
    endtask

    task automatic test_underflow();
        step(1'b1, 32'hD0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.data_out, bus.underflow, bus.count} !== {32'hC0, 1'b1, 3'd1}) begin
            failures++;
            $display("FAIL uf_set got=%h/%b/%0d exp=c0/1/1", bus.data_out, bus.underflow, bus.count);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.data_out !== 32'hD0 || dut_status !== model_status()) begin
            failures++;
            $display("FAIL uf_next_pop got=%h exp=%h", dut_status, model_status());
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.underflow !== 1'b0 || dut_status !== model_status()) begin
            failures++;
            $display("FAIL uf_clear got=%h exp=%h", dut_status, model_status());
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.underflow !== 1'b1 || dut_status !== model_status()) begin
            failures++;
            $display("FAIL uf_set_wins got=%h exp=%h", dut_status, model_status());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd3) begin
            failures++;
            $display("FAIL mid_fill got=%0d exp=3", bus.count);
        end
        step(1'b1, 32'hF3, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.count, bus.data_out, bus.empty} !== {3'd0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", dut_status, model_status());
        end
        step(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.data_out !== 32'hE0 || dut_status !== model_status()) begin
            failures++;
            $display("FAIL mid_after got=%h exp=%h", dut_status, model_status());
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.ext_valid = 1'b0;
        bus.ext_data  = '0;
        bus.load      = 1'b0;
        bus.clr_flags = 1'b0;
        m_dout        = '0;
        m_uf          = 1'b0;
        test_reset();
        test_fill_stall();
        test_wrap_order();
        test_concurrent();
        test_underflow();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
